// File: rtl/riscv_pkg.sv
// Shared opcodes, immediate/writeback codes, decode-stage FSM states and the ID/EX control bundle.
package riscv_pkg;

  localparam int unsigned OPC_W       = 7;
  localparam int unsigned REG_W       = 5;
  localparam int unsigned IMM_SEL_W   = 3;
  localparam int unsigned WB_SEL_W    = 2;
  localparam int unsigned FLUSH_CNT_W = 2;

  localparam logic [OPC_W-1:0] OPC_LOAD   = 7'b0000011;
  localparam logic [OPC_W-1:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [OPC_W-1:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [OPC_W-1:0] OPC_STORE  = 7'b0100011;
  localparam logic [OPC_W-1:0] OPC_OP     = 7'b0110011;
  localparam logic [OPC_W-1:0] OPC_LUI    = 7'b0110111;
  localparam logic [OPC_W-1:0] OPC_BRANCH = 7'b1100011;
  localparam logic [OPC_W-1:0] OPC_JALR   = 7'b1100111;
  localparam logic [OPC_W-1:0] OPC_JAL    = 7'b1101111;

  localparam logic [IMM_SEL_W-1:0] IMM_NONE = 3'b000;
  localparam logic [IMM_SEL_W-1:0] IMM_I    = 3'b001;
  localparam logic [IMM_SEL_W-1:0] IMM_S    = 3'b010;
  localparam logic [IMM_SEL_W-1:0] IMM_B    = 3'b011;
  localparam logic [IMM_SEL_W-1:0] IMM_J    = 3'b100;

  localparam logic [WB_SEL_W-1:0] WB_ALU = 2'b00;
  localparam logic [WB_SEL_W-1:0] WB_MEM = 2'b01;
  localparam logic [WB_SEL_W-1:0] WB_PC4 = 2'b10;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_STALL = 2'd1,
    ST_FLUSH = 2'd2
  } id_state_e;

  typedef struct packed {
    logic                reg_write;
    logic                mem_read;
    logic                mem_write;
    logic                branch;
    logic                jal;
    logic                alu_src;
    logic [WB_SEL_W-1:0] wb_sel;
  } ex_ctrl_t;

  localparam ex_ctrl_t EX_BUBBLE = '0;

endpackage

// File: rtl/ctrl_decode.sv
// Opcode decoder: immediate format, EX control bundle, source-register usage and illegal flag.
module ctrl_decode
  import riscv_pkg::*;
(
  input  logic [OPC_W-1:0]     opcode,
  output logic [IMM_SEL_W-1:0] imm_sel,
  output ex_ctrl_t             ctrl,
  output logic                 uses_rs1,
  output logic                 uses_rs2,
  output logic                 illegal
);

  // Per-opcode control table; unknown opcodes yield a bubble and no register usage.
  always_comb begin
    imm_sel  = IMM_NONE;
    ctrl     = EX_BUBBLE;
    uses_rs1 = 1'b0;
    uses_rs2 = 1'b0;
    illegal  = 1'b0;
    unique case (opcode)
      OPC_LOAD: begin
        imm_sel        = IMM_I;
        ctrl.reg_write = 1'b1;
        ctrl.mem_read  = 1'b1;
        ctrl.alu_src   = 1'b1;
        ctrl.wb_sel    = WB_MEM;
        uses_rs1       = 1'b1;
      end
      OPC_OP_IMM: begin
        imm_sel        = IMM_I;
        ctrl.reg_write = 1'b1;
        ctrl.alu_src   = 1'b1;
        uses_rs1       = 1'b1;
      end
      OPC_JALR: begin
        imm_sel        = IMM_I;
        ctrl.reg_write = 1'b1;
        ctrl.alu_src   = 1'b1;
        ctrl.wb_sel    = WB_PC4;
        uses_rs1       = 1'b1;
      end
      OPC_STORE: begin
        imm_sel        = IMM_S;
        ctrl.mem_write = 1'b1;
        ctrl.alu_src   = 1'b1;
        uses_rs1       = 1'b1;
        uses_rs2       = 1'b1;
      end
      OPC_BRANCH: begin
        imm_sel     = IMM_B;
        ctrl.branch = 1'b1;
        uses_rs1    = 1'b1;
        uses_rs2    = 1'b1;
      end
      OPC_JAL: begin
        imm_sel        = IMM_J;
        ctrl.reg_write = 1'b1;
        ctrl.jal       = 1'b1;
        ctrl.wb_sel    = WB_PC4;
      end
      OPC_OP: begin
        ctrl.reg_write = 1'b1;
        uses_rs1       = 1'b1;
        uses_rs2       = 1'b1;
      end
      OPC_LUI, OPC_AUIPC: begin
        ctrl.reg_write = 1'b1;
        ctrl.alu_src   = 1'b1;
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/id_stage_ctrl.sv
// Decode-stage sequencer: load-use stall, redirect flush, ID/EX control register, illegal-opcode pulse.
module id_stage_ctrl
  import riscv_pkg::*;
#(
  parameter int unsigned FLUSH_CYCLES = 1,
  parameter int unsigned XLEN         = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [XLEN-1:0]      if_id_ins,
  input  logic                 if_id_valid,
  input  logic                 id_ex_mem_read,
  input  logic [REG_W-1:0]     id_ex_rd,
  input  logic                 ex_redirect,
  output logic [IMM_SEL_W-1:0] imm_sel,
  output logic                 pc_write,
  output logic                 if_id_write,
  output logic                 if_id_flush,
  output logic                 ex_reg_write,
  output logic                 ex_mem_read,
  output logic                 ex_mem_write,
  output logic                 ex_branch,
  output logic                 ex_jal,
  output logic                 ex_alu_src,
  output logic [WB_SEL_W-1:0]  ex_wb_sel,
  output logic                 illegal_ins
);

  localparam logic [FLUSH_CNT_W-1:0] FLUSH_LOAD = FLUSH_CNT_W'(FLUSH_CYCLES);

  id_state_e               state_q, state_d;
  logic [FLUSH_CNT_W-1:0]  cnt_q, cnt_d;
  ex_ctrl_t                ctrl_q, ctrl_d;
  logic                    illegal_q, illegal_d;

  logic [IMM_SEL_W-1:0]    dec_imm_sel;
  ex_ctrl_t                dec_ctrl;
  logic                    dec_uses_rs1;
  logic                    dec_uses_rs2;
  logic                    dec_illegal;
  logic [REG_W-1:0]        rs1;
  logic [REG_W-1:0]        rs2;
  logic                    hazard_c;
  logic                    pc_write_c;
  logic                    if_id_write_c;
  logic                    if_id_flush_c;
  logic                    unused_ins;

  assign rs1        = if_id_ins[19:15];
  assign rs2        = if_id_ins[24:20];
  assign unused_ins = ^{if_id_ins[XLEN-1:25], if_id_ins[14:7]};

  ctrl_decode u_decode (
    .opcode   (if_id_ins[6:0]),
    .imm_sel  (dec_imm_sel),
    .ctrl     (dec_ctrl),
    .uses_rs1 (dec_uses_rs1),
    .uses_rs2 (dec_uses_rs2),
    .illegal  (dec_illegal)
  );

  // Immediate format goes straight to imm_gen; silent when IF/ID is empty.
  assign imm_sel = if_id_valid ? dec_imm_sel : IMM_NONE;

  // Load-use hazard against the load currently in EX.
  assign hazard_c = id_ex_mem_read && (id_ex_rd != '0) && if_id_valid &&
                    ((dec_uses_rs1 && (id_ex_rd == rs1)) ||
                     (dec_uses_rs2 && (id_ex_rd == rs2)));

  // Next state, flush counter and ID/EX payload; the STALL state blocks a second back-to-back stall.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    ctrl_d        = EX_BUBBLE;
    illegal_d     = 1'b0;
    pc_write_c    = 1'b1;
    if_id_write_c = 1'b1;
    if_id_flush_c = 1'b0;
    if (ex_redirect) begin
      if_id_flush_c = 1'b1;
      state_d       = ST_FLUSH;
      cnt_d         = FLUSH_LOAD;
    end else begin
      unique case (state_q)
        ST_RUN, ST_STALL: begin
          if (hazard_c && (state_q == ST_RUN)) begin
            pc_write_c    = 1'b0;
            if_id_write_c = 1'b0;
            state_d       = ST_STALL;
          end else begin
            state_d = ST_RUN;
            if (if_id_valid) begin
              if (dec_illegal) illegal_d = 1'b1;
              else             ctrl_d    = dec_ctrl;
            end
          end
        end
        ST_FLUSH: begin
          if (cnt_q <= FLUSH_CNT_W'(1)) begin
            state_d = ST_RUN;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q - FLUSH_CNT_W'(1);
          end
        end
        default: state_d = ST_RUN;
      endcase
    end
  end

  // Pipeline enables stay open and the flush stays quiet while reset is held.
  assign pc_write    = pc_write_c | ~rst_n;
  assign if_id_write = if_id_write_c | ~rst_n;
  assign if_id_flush = if_id_flush_c & rst_n;

  // State, flush counter, ID/EX control and illegal-pulse flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_RUN;
      cnt_q     <= '0;
      ctrl_q    <= EX_BUBBLE;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      ctrl_q    <= ctrl_d;
      illegal_q <= illegal_d;
    end
  end

  assign ex_reg_write = ctrl_q.reg_write;
  assign ex_mem_read  = ctrl_q.mem_read;
  assign ex_mem_write = ctrl_q.mem_write;
  assign ex_branch    = ctrl_q.branch;
  assign ex_jal       = ctrl_q.jal;
  assign ex_alu_src   = ctrl_q.alu_src;
  assign ex_wb_sel    = ctrl_q.wb_sel;
  assign illegal_ins  = illegal_q;

endmodule

// File: tb/tb_id_stage_ctrl.sv
// Directed bench for id_stage_ctrl: stalls, redirect flushes, decode and illegal-opcode handling.
module tb_id_stage_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] if_id_ins;
  logic        if_id_valid;
  logic        id_ex_mem_read;
  logic [4:0]  id_ex_rd;
  logic        ex_redirect;
  logic [2:0]  imm_sel;
  logic        pc_write, if_id_write, if_id_flush;
  logic        ex_reg_write, ex_mem_read, ex_mem_write, ex_branch, ex_jal, ex_alu_src;
  logic [1:0]  ex_wb_sel;
  logic        illegal_ins;

  int n_tests = 0;
  int n_fail  = 0;

  // Bundle order {reg_write, mem_read, mem_write, branch, jal, alu_src, wb_sel[1:0]}
  localparam logic [7:0] EX_NONE = 8'b0000_0000;
  localparam logic [7:0] EX_ADD  = 8'b1000_0000;
  localparam logic [7:0] EX_LUI  = 8'b1000_0100;
  localparam logic [7:0] EX_LW   = 8'b1100_0101;
  localparam logic [7:0] EX_BEQ  = 8'b0001_0000;
  localparam logic [7:0] EX_SW   = 8'b0010_0100;

  localparam logic [31:0] INS_ADD = 32'h0022_8333; // add x6,x5,x2
  localparam logic [31:0] INS_LUI = 32'h1234_52B7; // lui x5,0x12345 (rs1 field = 8)
  localparam logic [31:0] INS_LW  = 32'h0000_A283; // lw  x5,0(x1)
  localparam logic [31:0] INS_BEQ = 32'hFE20_8EE3; // beq x1,x2,-4
  localparam logic [31:0] INS_SW  = 32'h0051_2023; // sw  x5,0(x2)
  localparam logic [31:0] INS_BAD = 32'h0000_007F;

  always #5 clk = ~clk;

  id_stage_ctrl #(.FLUSH_CYCLES(1), .XLEN(32)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .if_id_ins      (if_id_ins),
    .if_id_valid    (if_id_valid),
    .id_ex_mem_read (id_ex_mem_read),
    .id_ex_rd       (id_ex_rd),
    .ex_redirect    (ex_redirect),
    .imm_sel        (imm_sel),
    .pc_write       (pc_write),
    .if_id_write    (if_id_write),
    .if_id_flush    (if_id_flush),
    .ex_reg_write   (ex_reg_write),
    .ex_mem_read    (ex_mem_read),
    .ex_mem_write   (ex_mem_write),
    .ex_branch      (ex_branch),
    .ex_jal         (ex_jal),
    .ex_alu_src     (ex_alu_src),
    .ex_wb_sel      (ex_wb_sel),
    .illegal_ins    (illegal_ins)
  );

  function automatic logic [7:0] ex_vec();
    return {ex_reg_write, ex_mem_read, ex_mem_write, ex_branch, ex_jal, ex_alu_src, ex_wb_sel};
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Inputs change 1 time unit after a rising edge, combinational checks 1 unit later.
  task automatic drive(input logic [31:0] ins, input logic vld, input logic mr,
                       input logic [4:0] rd, input logic redir);
    if_id_ins      = ins;
    if_id_valid    = vld;
    id_ex_mem_read = mr;
    id_ex_rd       = rd;
    ex_redirect    = redir;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    drive(32'h0, 1'b0, 1'b0, 5'd0, 1'b0);
    #10;
    chk("rst_ex", 32'(ex_vec()), 32'(EX_NONE));
    chk("rst_ill", 32'(illegal_ins), 32'd0);
    chk("rst_pcw", 32'(pc_write), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Load-use on rs1: one stall cycle, a bubble, then the add issues.
    drive(INS_ADD, 1'b1, 1'b1, 5'd5, 1'b0);
    chk("lu_pcw", 32'(pc_write), 32'd0);
    chk("lu_ifw", 32'(if_id_write), 32'd0);
    chk("lu_imm", 32'(imm_sel), 32'd0);
    tick();
    chk("lu_bubble", 32'(ex_vec()), 32'(EX_NONE));
    drive(INS_ADD, 1'b1, 1'b0, 5'd0, 1'b0);
    chk("lu_resume_pcw", 32'(pc_write), 32'd1);
    tick();
    chk("lu_issue", 32'(ex_vec()), 32'(EX_ADD));

    // Load with rd=x0: no stall.
    drive(INS_ADD, 1'b1, 1'b1, 5'd0, 1'b0);
    chk("x0_pcw", 32'(pc_write), 32'd1);
    tick();
    chk("x0_issue", 32'(ex_vec()), 32'(EX_ADD));

    // lui does not read rs1 even when its field matches the load rd.
    drive(INS_LUI, 1'b1, 1'b1, 5'd8, 1'b0);
    chk("lui_pcw", 32'(pc_write), 32'd1);
    chk("lui_imm", 32'(imm_sel), 32'd0);
    tick();
    chk("lui_issue", 32'(ex_vec()), 32'(EX_LUI));

    // lw, beq, sw decode.
    drive(INS_LW, 1'b1, 1'b0, 5'd0, 1'b0);
    chk("lw_imm", 32'(imm_sel), 32'd1);
    tick();
    chk("lw_issue", 32'(ex_vec()), 32'(EX_LW));
    drive(INS_BEQ, 1'b1, 1'b0, 5'd0, 1'b0);
    chk("beq_imm", 32'(imm_sel), 32'd3);
    tick();
    chk("beq_issue", 32'(ex_vec()), 32'(EX_BEQ));
    drive(INS_SW, 1'b1, 1'b0, 5'd0, 1'b0);
    chk("sw_imm", 32'(imm_sel), 32'd2);
    tick();
    chk("sw_issue", 32'(ex_vec()), 32'(EX_SW));

    // sw reading the load result through rs2 stalls.
    drive(INS_SW, 1'b1, 1'b1, 5'd5, 1'b0);
    chk("rs2_pcw", 32'(pc_write), 32'd0);
    tick();
    chk("rs2_bubble", 32'(ex_vec()), 32'(EX_NONE));
    drive(INS_SW, 1'b1, 1'b0, 5'd0, 1'b0);
    tick();
    chk("rs2_issue", 32'(ex_vec()), 32'(EX_SW));

    // Invalid IF/ID: no immediate, bubble.
    drive(INS_LW, 1'b0, 1'b0, 5'd0, 1'b0);
    chk("inv_imm", 32'(imm_sel), 32'd0);
    tick();
    chk("inv_bubble", 32'(ex_vec()), 32'(EX_NONE));

    // Redirect with FLUSH_CYCLES=1: two bubble edges, then issue.
    drive(INS_ADD, 1'b1, 1'b0, 5'd0, 1'b1);
    chk("rd_flush", 32'(if_id_flush), 32'd1);
    chk("rd_pcw", 32'(pc_write), 32'd1);
    chk("rd_ifw", 32'(if_id_write), 32'd1);
    tick();
    chk("rd_bub1", 32'(ex_vec()), 32'(EX_NONE));
    drive(INS_ADD, 1'b1, 1'b0, 5'd0, 1'b0);
    chk("rd_flush_off", 32'(if_id_flush), 32'd0);
    tick();
    chk("rd_bub2", 32'(ex_vec()), 32'(EX_NONE));
    tick();
    chk("rd_resume", 32'(ex_vec()), 32'(EX_ADD));

    // Redirect and hazard together: redirect wins.
    drive(INS_ADD, 1'b1, 1'b1, 5'd5, 1'b1);
    chk("rh_pcw", 32'(pc_write), 32'd1);
    chk("rh_flush", 32'(if_id_flush), 32'd1);
    tick();
    chk("rh_bub1", 32'(ex_vec()), 32'(EX_NONE));
    drive(INS_ADD, 1'b1, 1'b0, 5'd0, 1'b0);
    tick();
    chk("rh_bub2", 32'(ex_vec()), 32'(EX_NONE));
    tick();
    chk("rh_resume", 32'(ex_vec()), 32'(EX_ADD));

    // Unknown opcode: bubble and a single-cycle illegal pulse.
    drive(INS_BAD, 1'b1, 1'b0, 5'd0, 1'b0);
    chk("ill_imm", 32'(imm_sel), 32'd0);
    chk("ill_pcw", 32'(pc_write), 32'd1);
    tick();
    chk("ill_bubble", 32'(ex_vec()), 32'(EX_NONE));
    chk("ill_pulse", 32'(illegal_ins), 32'd1);
    drive(INS_ADD, 1'b1, 1'b0, 5'd0, 1'b0);
    tick();
    chk("ill_clear", 32'(illegal_ins), 32'd0);
    chk("ill_next", 32'(ex_vec()), 32'(EX_ADD));

    // Reset asserted during a stall clears ID/EX at once and reopens the PC.
    drive(INS_LUI, 1'b1, 1'b0, 5'd0, 1'b0);
    tick();
    chk("rs_pre", 32'(ex_vec()), 32'(EX_LUI));
    drive(INS_ADD, 1'b1, 1'b1, 5'd5, 1'b0);
    chk("rs_stall", 32'(pc_write), 32'd0);
    rst_n = 1'b0;
    #1;
    chk("rs_ex", 32'(ex_vec()), 32'(EX_NONE));
    chk("rs_pcw", 32'(pc_write), 32'd1);
    drive(INS_ADD, 1'b1, 1'b0, 5'd0, 1'b0);
    rst_n = 1'b1;
    tick();
    chk("rs_run_issue", 32'(ex_vec()), 32'(EX_ADD));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
